div_16x8_signed_seq: RTL and testbench

DIV_16X8_SIGNED_SEQ -- requirements
Module: div_16x8_signed_seq

---
 rtl/div_16x8_signed_seq.sv | 165 ++++++++++++++++
 tb/tb_div_16x8_signed_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/div_16x8_signed_seq.sv
// Signed sequential divider: a (MAC_OUT_WIDTH) / b (MAC_IN_WIDTH), truncating, radix-2 restoring.
// Latency: MAC_OUT_WIDTH enabled edges after accept; divide-by-zero and MIN/-1 overflow finish on the accept edge.
// Backpressure: result held in DONE until i_ready; o_ready only in IDLE; i_en_ff=0 freezes everything.
// Ports: i_clk/i_rst (sync, active-high), i_en_ff clock enable,
//        i_valid/o_ready + a,b request; o_valid/i_ready + quo,rem,o_div0,o_ovf result.
module div_16x8_signed_seq #(
  parameter int MAC_IN_WIDTH  = 8,
  parameter int MAC_OUT_WIDTH = MAC_IN_WIDTH * 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en_ff,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [MAC_OUT_WIDTH-1:0] a,
  input  logic [MAC_IN_WIDTH-1:0]  b,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [MAC_OUT_WIDTH-1:0] quo,
  output logic [MAC_IN_WIDTH-1:0]  rem,
  output logic                     o_div0,
  output logic                     o_ovf
);

  localparam int NW = MAC_OUT_WIDTH;
  localparam int DW = MAC_IN_WIDTH;
  localparam int CW = $clog2(NW);
  localparam logic [NW-1:0] QMAX = {1'b0, {(NW-1){1'b1}}};
  localparam logic [NW-1:0] QMIN = {1'b1, {(NW-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(NW - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [NW-1:0]   r_num;    // |a| shifting out MSB-first, quotient bits shifting in
  logic [DW-1:0]   r_part;   // partial remainder
  logic [DW-1:0]   r_den;    // |b|
  logic            r_neg_q;
  logic            r_neg_r;
  logic [NW-1:0]   r_quo;
  logic [DW-1:0]   r_rem;
  logic            r_div0;
  logic            r_ovf;

  logic            w_accept;
  logic            w_last;
  logic            w_b_zero;
  logic            w_ovf_case;
  logic [NW-1:0]   w_abs_a;
  logic [DW-1:0]   w_abs_b;
  logic [DW:0]     w_shift;
  logic            w_ge;
  logic [DW-1:0]   w_diff;
  logic [DW-1:0]   w_part_nxt;
  logic [NW-1:0]   w_num_nxt;
  logic [NW-1:0]   w_quo_fin;
  logic [DW-1:0]   w_rem_fin;

  // Magnitudes are held unsigned, so the most negative inputs map exactly
  // (0x8000 -> 32768, 0x80 -> 128) without needing an extra bit.
  assign w_abs_a    = a[NW-1] ? (~a + 1'b1) : a;
  assign w_abs_b    = b[DW-1] ? (~b + 1'b1) : b;
  assign w_b_zero   = (b == '0);
  assign w_ovf_case = (a == QMIN) && (b == '1);

  // One restoring step. The partial remainder is always < |b| <= 2^(DW-1),
  // so the difference fits in DW bits and the modular subtract is exact.
  assign w_shift    = {r_part, r_num[NW-1]};
  assign w_ge       = (w_shift >= {1'b0, r_den});
  assign w_diff     = w_shift[DW-1:0] - r_den;
  assign w_part_nxt = w_ge ? w_diff : w_shift[DW-1:0];
  assign w_num_nxt  = {r_num[NW-2:0], w_ge};
  assign w_quo_fin  = r_neg_q ? (~w_num_nxt + 1'b1) : w_num_nxt;
  assign w_rem_fin  = r_neg_r ? (~w_part_nxt + 1'b1) : w_part_nxt;

  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    o_valid     = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (w_b_zero || w_ovf_case) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == LAST) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_valid = 1'b1;
        if (i_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else if (i_en_ff) begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_num   <= '0;
      r_part  <= '0;
      r_den   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_div0  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (i_en_ff) begin
      if (w_accept) begin
        r_cnt   <= '0;
        r_num   <= w_abs_a;
        r_part  <= '0;
        r_den   <= w_abs_b;
        r_neg_q <= a[NW-1] ^ b[DW-1];
        r_neg_r <= a[NW-1];
        // Special cases publish their result on the accept edge itself.
        if (w_b_zero) begin
          r_quo  <= a[NW-1] ? QMIN : QMAX;
          r_rem  <= '0;
          r_div0 <= 1'b1;
          r_ovf  <= 1'b0;
        end else if (w_ovf_case) begin
          r_quo  <= QMAX;
          r_rem  <= '0;
          r_div0 <= 1'b0;
          r_ovf  <= 1'b1;
        end
      end else if (r_state == S_CALC) begin
        r_cnt  <= r_cnt + 1'b1;
        r_num  <= w_num_nxt;
        r_part <= w_part_nxt;
        if (w_last) begin
          r_quo  <= w_quo_fin;
          r_rem  <= w_rem_fin;
          r_div0 <= 1'b0;
          r_ovf  <= 1'b0;
        end
      end
    end
  end

  assign quo    = r_quo;
  assign rem    = r_rem;
  assign o_div0 = r_div0;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_div_16x8_signed_seq.sv
// Directed and randomized checks of the signed sequential divider.
module tb_div_16x8_signed_seq;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_en_ff;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] a;
  logic [7:0]  b;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] quo;
  logic [7:0]  rem;
  logic        o_div0;
  logic        o_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  div_16x8_signed_seq #(.MAC_IN_WIDTH(8), .MAC_OUT_WIDTH(16)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en_ff (i_en_ff),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .a       (a),
    .b       (b),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .quo     (quo),
    .rem     (rem),
    .o_div0  (o_div0),
    .o_ovf   (o_ovf)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait for the result; i_en_ff is dropped for
  // st_len edges starting st_at edges after the accept edge.
  task automatic do_op(input string tag, input logic [15:0] ta, input logic [7:0] tb,
                       input logic [15:0] eq, input logic [7:0] er,
                       input logic ed, input logic eo, input int elat,
                       input int st_at, input int st_len);
    int n;
    a = ta; b = tb; i_valid = 1'b1; i_en_ff = 1'b1;
    tick();
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 200) begin
      i_en_ff = !(n >= st_at && n < st_at + st_len);
      tick();
      n++;
    end
    i_en_ff = 1'b1;
    check({tag, ".lat"},   n,       elat);
    check({tag, ".quo"},   quo,     eq);
    check({tag, ".rem"},   rem,     er);
    check({tag, ".div0"},  o_div0,  ed);
    check({tag, ".ovf"},   o_ovf,   eo);
    check({tag, ".ready"}, o_ready, 1'b0);
  endtask

  task automatic release_result(input string tag);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check({tag, ".rel_valid"}, o_valid, 1'b0);
    check({tag, ".rel_ready"}, o_ready, 1'b1);
  endtask

  initial begin
    logic [15:0] hq;
    logic [7:0]  hr;
    i_rst = 1'b1; i_en_ff = 1'b1; i_valid = 1'b0; i_ready = 1'b0; a = '0; b = '0;
    tick(); tick();
    i_rst = 1'b0;
    check("rst.ready", o_ready, 1'b1);
    check("rst.valid", o_valid, 1'b0);
    check("rst.quo",   quo,     16'h0);
    check("rst.rem",   rem,     8'h0);
    check("rst.div0",  o_div0,  1'b0);
    check("rst.ovf",   o_ovf,   1'b0);

    // Directed vectors: expected values computed by hand.
    do_op("p100d7",  16'd100,  8'd7,    16'd14,   8'd2,   1'b0, 1'b0, 16, 1000, 0); release_result("p100d7");
    do_op("m100d7",  16'hFF9C, 8'd7,    16'hFFF2, 8'hFE,  1'b0, 1'b0, 16, 1000, 0); release_result("m100d7");
    do_op("minDm128",16'h8000, 8'h80,   16'd256,  8'd0,   1'b0, 1'b0, 16, 1000, 0); release_result("minDm128");
    do_op("ovf",     16'h8000, 8'hFF,   16'h7FFF, 8'd0,   1'b0, 1'b1, 0,  1000, 0); release_result("ovf");
    do_op("div0pos", 16'd1234, 8'd0,    16'h7FFF, 8'd0,   1'b1, 1'b0, 0,  1000, 0); release_result("div0pos");
    do_op("div0neg", 16'hFFFB, 8'd0,    16'h8000, 8'd0,   1'b1, 1'b0, 0,  1000, 0); release_result("div0neg");
    do_op("maxD1",   16'h7FFF, 8'd1,    16'h7FFF, 8'd0,   1'b0, 1'b0, 16, 1000, 0); release_result("maxD1");
    do_op("minD1",   16'h8000, 8'd1,    16'h8000, 8'd0,   1'b0, 1'b0, 16, 1000, 0); release_result("minD1");
    do_op("p7dm2",   16'd7,    8'hFE,   16'hFFFD, 8'd1,   1'b0, 1'b0, 16, 1000, 0); release_result("p7dm2");
    do_op("maxDm128",16'h7FFF, 8'h80,   16'hFF01, 8'd127, 1'b0, 1'b0, 16, 1000, 0); release_result("maxDm128");
    do_op("minD127", 16'h8000, 8'd127,  16'hFEFE, 8'hFE,  1'b0, 1'b0, 16, 1000, 0); release_result("minD127");

    // Reset after the 8th iteration, applied with i_en_ff low.
    a = 16'd100; b = 8'd7; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    i_rst = 1'b1; i_en_ff = 1'b0;
    tick();
    i_rst = 1'b0; i_en_ff = 1'b1;
    check("midrst.ready", o_ready, 1'b1);
    check("midrst.valid", o_valid, 1'b0);
    check("midrst.quo",   quo,     16'h0);
    check("midrst.rem",   rem,     8'h0);
    check("midrst.div0",  o_div0,  1'b0);
    do_op("postrst", 16'd100, 8'd7, 16'd14, 8'd2, 1'b0, 1'b0, 16, 1000, 0); release_result("postrst");

    // Five disabled edges in mid-calculation push the result out by five.
    do_op("stall", 16'd100, 8'd7, 16'd14, 8'd2, 1'b0, 1'b0, 21, 3, 5); release_result("stall");

    // Backpressure with a competing request, then a disabled handshake edge.
    do_op("bp", 16'hFFF9, 8'd2, 16'hFFFD, 8'hFF, 1'b0, 1'b0, 16, 1000, 0);
    hq = quo; hr = rem;
    a = 16'd55; b = 8'd3; i_valid = 1'b1; i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp.valid", o_valid, 1'b1);
      check("bp.ready", o_ready, 1'b0);
      check("bp.quo",   quo,     hq);
      check("bp.rem",   rem,     hr);
    end
    i_en_ff = 1'b0; i_ready = 1'b1;
    tick();
    check("bp.en0_valid", o_valid, 1'b1);
    i_en_ff = 1'b1;
    tick();
    i_ready = 1'b0;
    check("bp.hs_valid", o_valid, 1'b0);
    check("bp.hs_ready", o_ready, 1'b1);
    do_op("p55d3", 16'd55, 8'd3, 16'd18, 8'd1, 1'b0, 1'b0, 16, 1000, 0); release_result("p55d3");

    // Random sweep with enable and ready stalls against an integer model.
    for (int t = 0; t < 2000; t++) begin
      logic [15:0] ra;
      logic [7:0]  rb;
      logic [15:0] eq;
      logic [7:0]  er;
      logic        ed, eo, seen, done, hs;
      int          ai, bi, qi, ri, cnt;
      ra = 16'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 15) == 0) rb = 8'h00;
      if ($urandom_range(0, 31) == 0) begin ra = 16'h8000; rb = 8'hFF; end
      ai = $signed(ra);
      bi = $signed(rb);
      ed = 1'b0; eo = 1'b0;
      if (bi == 0) begin
        eq = (ai >= 0) ? 16'h7FFF : 16'h8000; er = 8'h00; ed = 1'b1;
      end else if (ai == -32768 && bi == -1) begin
        eq = 16'h7FFF; er = 8'h00; eo = 1'b1;
      end else begin
        eq = 16'(ai / bi); er = 8'(ai % bi);
      end
      a = ra; b = rb; i_valid = 1'b1; i_en_ff = 1'b1; i_ready = 1'b0;
      tick();
      i_valid = 1'b0;
      seen = 1'b0; done = 1'b0; cnt = 0;
      while (!done && cnt < 400) begin
        if (o_valid && !seen) begin
          seen = 1'b1;
          check("rnd.quo",  quo,    eq);
          check("rnd.rem",  rem,    er);
          check("rnd.div0", o_div0, ed);
          check("rnd.ovf",  o_ovf,  eo);
          if (!ed && !eo) begin
            qi = $signed(quo);
            ri = $signed(rem);
            check("rnd.identity", qi * bi + ri, ai);
            check("rnd.remmag", ((ri < 0 ? -ri : ri) < (bi < 0 ? -bi : bi)) ? 1 : 0, 1);
            check("rnd.remsign", (ri == 0 || ((ri < 0) == (ai < 0))) ? 1 : 0, 1);
          end
        end
        i_en_ff = ($urandom_range(0, 7) != 0);
        i_ready = ($urandom_range(0, 3) != 0);
        hs = o_valid && i_en_ff && i_ready;
        tick();
        cnt++;
        if (hs) done = 1'b1;
      end
      i_en_ff = 1'b1; i_ready = 1'b0;
      check("rnd.completed", done, 1'b1);
      if (!done) break;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
